// File: rtl/rdn_pkg.sv
// Shared types and width helpers for the rotation-detection-network layer engine.
package rdn_pkg;

    typedef enum logic [1:0] {
        ACT_LINEAR = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_STEP   = 2'd2
    } act_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/rdn_layer_engine_if.sv
// Weight-write, input-vector and result-vector handshake bundle of the layer engine.
interface rdn_layer_engine_if #(
    parameter int unsigned NUM_IN  = 400,
    parameter int unsigned NUM_OUT = 15,
    parameter int unsigned IN_W    = 8,
    parameter int unsigned W_W     = 16,
    parameter int unsigned OUT_W   = 16
);
    localparam int unsigned NW = rdn_pkg::idx_w(NUM_OUT);
    localparam int unsigned IW = rdn_pkg::idx_w(NUM_IN + 1);

    logic                             wr_en;
    logic [NW-1:0]                    wr_neuron;
    logic [IW-1:0]                    wr_idx;
    logic [W_W-1:0]                   wr_data;
    logic                             wr_ready;
    logic                             in_valid;
    logic                             in_ready;
    logic [NUM_IN-1:0][IN_W-1:0]      in_data;
    logic [1:0]                       act_mode;
    logic                             out_valid;
    logic                             out_ready;
    logic [NUM_OUT-1:0][OUT_W-1:0]    out_data;

    modport master (
        output wr_en, wr_neuron, wr_idx, wr_data, in_valid, in_data, act_mode, out_ready,
        input  wr_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  wr_en, wr_neuron, wr_idx, wr_data, in_valid, in_data, act_mode, out_ready,
        output wr_ready, in_ready, out_valid, out_data
    );

endinterface

// File: rtl/rdn_mac_lane.sv
// One signed multiply-accumulate lane with bias load and activation/saturation output.
module rdn_mac_lane
    import rdn_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned W_W   = 16,
    parameter int unsigned ACC_W = 36,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic signed [IN_W-1:0]  x,
    input  logic signed [W_W-1:0]   w,
    input  act_mode_t               mode,
    output logic [OUT_W-1:0]        res_c
);
    localparam int unsigned P_W = IN_W + W_W;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [P_W-1:0]   prod_c;
    logic signed [ACC_W-1:0] shr_c;
    logic signed [63:0]      sat_c;

    assign prod_c = P_W'(x) * P_W'(w);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= load ? ACC_W'(w) : acc_q + ACC_W'(prod_c);
        end
    end

    // Accumulator is in weight fixed point; drop the fraction with floor before saturating.
    always_comb begin
        shr_c = acc_q >>> FRAC;
        sat_c = sat_signed(64'(shr_c), OUT_W);
        res_c = OUT_W'(sat_c);
        case (mode)
            ACT_STEP: res_c = (!acc_q[ACC_W-1] && (acc_q != '0)) ? OUT_W'(1) : '0;
            ACT_RELU: res_c = shr_c[ACC_W-1] ? '0 : OUT_W'(sat_c);
            default:  res_c = OUT_W'(sat_c);
        endcase
    end

endmodule

// File: rtl/rdn_layer_engine.sv
// Time-multiplexed fully-connected layer: LANES MAC lanes sweep NUM_OUT neurons in groups.
module rdn_layer_engine
    import rdn_pkg::*;
#(
    parameter int unsigned NUM_IN  = 400,
    parameter int unsigned NUM_OUT = 15,
    parameter int unsigned LANES   = 4,
    parameter int unsigned IN_W    = 8,
    parameter int unsigned W_W     = 16,
    parameter int unsigned FRAC    = 8,
    parameter int unsigned ACC_W   = 36,
    parameter int unsigned OUT_W   = 16
) (
    input logic               clk,
    input logic               rst,
    rdn_layer_engine_if.slave bus
);
    localparam int unsigned NW      = idx_w(NUM_OUT);
    localparam int unsigned IW      = idx_w(NUM_IN + 1);
    localparam int unsigned NGROUPS = ceil_div(NUM_OUT, LANES);
    localparam int unsigned GW      = idx_w(NGROUPS);
    localparam logic [IW-1:0] K_LAST = IW'(NUM_IN);
    localparam logic [GW-1:0] G_LAST = GW'(NGROUPS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NUM_OUT - 1);

    if (ACC_W < IN_W + W_W + $clog2(NUM_IN + 1)) begin : g_acc_w_chk
        $error("ACC_W too narrow to accumulate NUM_IN products plus bias");
    end

    state_t                        state_q;
    act_mode_t                     mode_q;
    logic [IW-1:0]                 k_q;
    logic [GW-1:0]                 g_q;
    logic signed [W_W-1:0]         weights_q [NUM_OUT][NUM_IN+1];
    logic signed [IN_W-1:0]        in_q [NUM_IN+1];
    logic [NUM_OUT-1:0][OUT_W-1:0] out_q;
    logic                          out_valid_q;

    logic [NW-1:0]         lane_n   [LANES];
    logic                  lane_ok  [LANES];
    logic signed [W_W-1:0] lane_w   [LANES];
    logic [OUT_W-1:0]      lane_res [LANES];

    // in_q[0] stays zero so slot k lines up with weight index k (slot 0 is the bias).
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0] n_full;
        assign n_full     = 32'(g_q) * 32'(LANES) + 32'(l);
        assign lane_ok[l] = n_full < 32'(NUM_OUT);
        assign lane_n[l]  = NW'(n_full);
        assign lane_w[l]  = lane_ok[l] ? weights_q[lane_n[l]][k_q] : '0;

        rdn_mac_lane #(
            .IN_W (IN_W),
            .W_W  (W_W),
            .ACC_W(ACC_W),
            .FRAC (FRAC),
            .OUT_W(OUT_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   ((state_q == MAC) && lane_ok[l]),
            .load (k_q == '0),
            .x    (in_q[k_q]),
            .w    (lane_w[l]),
            .mode (mode_q),
            .res_c(lane_res[l])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= ACT_LINEAR;
            k_q         <= '0;
            g_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int unsigned n = 0; n < NUM_OUT; n++) begin
                for (int unsigned i = 0; i <= NUM_IN; i++) weights_q[n][i] <= '0;
            end
            for (int unsigned i = 0; i <= NUM_IN; i++) in_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.wr_en) begin
                        if (bus.wr_neuron <= N_LAST && bus.wr_idx <= K_LAST)
                            weights_q[bus.wr_neuron][bus.wr_idx] <= bus.wr_data;
                    end else if (bus.in_valid) begin
                        for (int unsigned i = 0; i < NUM_IN; i++) in_q[i+1] <= bus.in_data[i];
                        mode_q  <= (bus.act_mode == 2'd1) ? ACT_RELU :
                                   (bus.act_mode == 2'd2) ? ACT_STEP : ACT_LINEAR;
                        k_q     <= '0;
                        g_q     <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    if (k_q == K_LAST) state_q <= ACT;
                    else               k_q     <= k_q + IW'(1);
                end
                ACT: begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        if (lane_ok[l]) out_q[lane_n[l]] <= lane_res[l];
                    end
                    if (g_q == G_LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        g_q     <= g_q + GW'(1);
                        k_q     <= '0;
                        state_q <= MAC;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wr_ready  = (state_q == IDLE);
    assign bus.in_ready  = (state_q == IDLE) && !bus.wr_en && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;

endmodule

// File: tb/tb_rdn_layer_engine.sv
// Scoreboard bench for rdn_layer_engine with NUM_IN=4, NUM_OUT=3, LANES=2, OUT_W=8.
module tb_rdn_layer_engine;
    localparam int unsigned NUM_IN  = 4;
    localparam int unsigned NUM_OUT = 3;
    localparam int unsigned LANES   = 2;
    localparam int unsigned IN_W    = 8;
    localparam int unsigned W_W     = 16;
    localparam int unsigned FRAC    = 8;
    localparam int unsigned ACC_W   = 36;
    localparam int unsigned OUT_W   = 8;
    localparam int          LAT     = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   pop_cyc;
    bit   ov_prev = 1'b0;

    logic [23:0] exp_q[$];
    int          lat_q[$];

    rdn_layer_engine_if #(
        .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .IN_W(IN_W), .W_W(W_W), .OUT_W(OUT_W)
    ) bus ();

    rdn_layer_engine #(
        .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .LANES(LANES), .IN_W(IN_W), .W_W(W_W),
        .FRAC(FRAC), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h need 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [23:0] pack3(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [31:0] vec4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Monitor: latency on out_valid rise, data on every output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && !ov_prev) begin
                if (lat_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL latency: out_valid rose with no pending transaction");
                end else begin
                    pop_cyc = lat_q.pop_front();
                    chk("latency", 64'(cyc - pop_cyc), 64'(LAT));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out_data: unexpected result 0x%0h", bus.out_data);
                end else begin
                    chk("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
                end
            end
        end
        ov_prev = bus.out_valid;
    end

    task automatic wr(input int n, input int idx, input int data);
        bus.wr_neuron = 2'(n);
        bus.wr_idx    = 3'(idx);
        bus.wr_data   = 16'(data);
        bus.wr_en     = 1'b1;
        @(posedge clk); #1;
        bus.wr_en     = 1'b0;
    endtask

    task automatic set_neuron(input int n, input int w, input int bias);
        wr(n, 0, bias);
        for (int k = 1; k <= 4; k++) wr(n, k, w);
    endtask

    // opt: 0 plain, 1 write with input, 2 write while busy, 3 reset mid-MAC, 4 hold out_ready low
    task automatic run(input logic [31:0] x, input logic [1:0] mode, input logic [23:0] expv,
                       input int opt);
        int w_cyc;
        int a_cyc;
        int n;
        w_cyc = 0;
        bus.in_data  = x;
        bus.act_mode = mode;
        bus.in_valid = 1'b1;
        if (opt == 4) bus.out_ready = 1'b0;
        if (opt == 1) begin
            bus.wr_neuron = 2'd2; bus.wr_idx = 3'd1; bus.wr_data = 16'd256; bus.wr_en = 1'b1;
            @(negedge clk);
            chk("in_ready_during_wr", 64'(bus.in_ready), 64'(0));
            @(posedge clk); #1;
            bus.wr_en = 1'b0;
            w_cyc = cyc;
        end
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready never rose");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        a_cyc = cyc;
        bus.in_valid = 1'b0;
        if (opt == 1) chk("accept_after_wr", 64'(a_cyc), 64'(w_cyc + 1));
        if (opt == 3) begin
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            #1;
            chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
            chk("rst_out_data", 64'(bus.out_data), 64'(0));
            chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            chk("post_rst_out_valid", 64'(bus.out_valid), 64'(0));
            chk("post_rst_wr_ready", 64'(bus.wr_ready), 64'(1));
            return;
        end
        exp_q.push_back(expv);
        lat_q.push_back(a_cyc);
        if (opt == 2) begin
            repeat (2) @(posedge clk);
            #1;
            bus.wr_neuron = 2'd2; bus.wr_idx = 3'd1; bus.wr_data = 16'd999; bus.wr_en = 1'b1;
            @(negedge clk);
            chk("busy_wr_ready", 64'(bus.wr_ready), 64'(0));
            @(posedge clk); #1 bus.wr_en = 1'b0;
        end
        if (opt == 4) begin
            n = 0;
            while (n < 100) begin
                @(negedge clk);
                if (bus.out_valid) break;
                n++;
            end
            repeat (5) begin
                @(negedge clk);
                chk("hold_out_valid", 64'(bus.out_valid), 64'(1));
                chk("hold_out_data", 64'(bus.out_data), 64'(expv));
                chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
                chk("hold_wr_ready", 64'(bus.wr_ready), 64'(0));
            end
            @(posedge clk); #1 bus.out_ready = 1'b1;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL result_timeout: no output handshake");
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en = 1'b0; bus.wr_neuron = '0; bus.wr_idx = '0; bus.wr_data = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.act_mode = 2'd0; bus.out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", 64'(bus.in_ready), 64'(0));
        chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset_out_data", 64'(bus.out_data), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("after_reset_wr_ready", 64'(bus.wr_ready), 64'(1));
        chk("after_reset_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;

        set_neuron(0, 256, 0);
        run(vec4(1, 2, 3, 4), 2'd0, pack3(10, 0, 0), 0);
        set_neuron(1, -256, 0);
        run(vec4(1, 2, 3, 4), 2'd0, pack3(10, -10, 0), 0);
        run(vec4(1, 2, 3, 4), 2'd1, pack3(10, 0, 0), 0);
        set_neuron(2, 256, 512);
        run(vec4(100, 100, 100, 100), 2'd0, pack3(127, -128, 127), 0);
        set_neuron(2, -256, 0);
        run(vec4(100, 100, 100, 100), 2'd0, pack3(127, -128, -128), 0);
        set_neuron(2, 0, 0);
        run(vec4(1, 2, 3, 4), 2'd2, pack3(1, 0, 0), 0);
        run(vec4(1, 2, 3, 4), 2'd3, pack3(10, -10, 0), 0);
        run(vec4(1, 2, 3, 4), 2'd0, pack3(10, -10, 0), 4);
        run(vec4(1, 2, 3, 4), 2'd0, pack3(10, -10, 1), 1);
        run(vec4(1, 2, 3, 4), 2'd0, pack3(10, -10, 1), 2);
        run(vec4(1, 2, 3, 4), 2'd0, pack3(10, -10, 1), 0);
        @(negedge clk);
        chk("idle_out_data_kept", 64'(bus.out_data), 64'(pack3(10, -10, 1)));
        chk("idle_out_valid", 64'(bus.out_valid), 64'(0));
        @(posedge clk); #1;
        run(vec4(1, 2, 3, 4), 2'd0, pack3(0, 0, 0), 3);
        @(posedge clk); #1;
        run(vec4(1, 2, 3, 4), 2'd0, pack3(0, 0, 0), 0);
        run(vec4(5, 6, 7, 8), 2'd2, pack3(0, 0, 0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
